bidir_bus_ctrl: RTL and testbench

BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

---
 rtl/bus_ctrl_pkg.sv | 27 ++
 rtl/bus_wait_counter.sv | 47 ++++
 rtl/bidir_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_bidir_bus_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bus_ctrl_pkg
//  Purpose  : Shared state encoding and default sizing for the bidirectional
//             external bus controller and its wait-state counter.
//  Revision : 1.0  initial release
// ============================================================================
package bus_ctrl_pkg;

  localparam int DEF_DW          = 8;
  localparam int DEF_AW          = 16;
  localparam int DEF_WAIT_STATES = 2;

  // Wait counter width; WAIT_STATES is limited to 0..15.
  localparam int WCNT_W = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_TURN   = 3'd4;

endpackage : bus_ctrl_pkg
`default_nettype wire

// File: rtl/bus_wait_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bus_wait_counter
//  Purpose  : Loadable down-counter with zero flag that times the strobe
//             phase of an external bus access.
//  Revision : 1.0  initial release
// ============================================================================
module bus_wait_counter
  import bus_ctrl_pkg::*;
#(
  parameter int W = WCNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule : bus_wait_counter
`default_nettype wire

// File: rtl/bidir_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bidir_bus_ctrl
//  Purpose  : Single-access controller for an external bidirectional data bus
//             built from pad cells (A / TN / ZI). Sequences SETUP, STROBE,
//             HOLD and a read-to-write turnaround; all outputs registered.
//  Revision : 1.0  initial release
// ============================================================================
module bidir_bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int AW          = DEF_AW,
  parameter int WAIT_STATES = DEF_WAIT_STATES  // 0..15
) (
  input  logic          MasterClock,
  input  logic          Reset,
  input  logic          Req,
  input  logic          We,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] WData,
  output logic          Ack,
  output logic [DW-1:0] RData,
  input  logic          TestEn,
  output logic [AW-1:0] PadAddr,
  output logic [DW-1:0] PadA,
  output logic          PadTN,
  input  logic [DW-1:0] PadZI,
  output logic          nRD,
  output logic          nWR
);

  state_t        state_q,    state_d;
  logic          we_q,       we_d;
  logic [AW-1:0] pad_addr_q, pad_addr_d;
  logic [DW-1:0] pad_a_q,    pad_a_d;
  logic          pad_tn_q,   pad_tn_d;
  logic          n_rd_q,     n_rd_d;
  logic          n_wr_q,     n_wr_d;
  logic          ack_q,      ack_d;
  logic [DW-1:0] rdata_q,    rdata_d;

  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;

  bus_wait_counter #(
    .W (WCNT_W)
  ) u_wait_cnt (
    .clk        (MasterClock),
    .rst        (Reset),
    .i_load     (cnt_load),
    .i_load_val (WCNT_W'(WAIT_STATES)),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // every pad-facing signal comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    pad_addr_d = pad_addr_q;
    pad_a_d    = pad_a_q;
    pad_tn_d   = pad_tn_q;
    n_rd_d     = 1'b1;
    n_wr_d     = 1'b1;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pad_tn_d = 1'b0;
        if (Req && !TestEn) begin
          we_d       = We;
          pad_addr_d = Addr;
          pad_a_d    = WData;
          pad_tn_d   = We;       // drive only for writes, from SETUP onward
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_load = 1'b1;
        n_wr_d   = !we_q;
        n_rd_d   = we_q;
        state_d  = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          ack_d   = 1'b1;
          // PadZI already passed through the pad register, so the value
          // present now is the device data from the strobe window.
          if (!we_q) begin
            rdata_d = PadZI;
          end
        end else begin
          cnt_dec = 1'b1;
          n_wr_d  = !we_q;
          n_rd_d  = we_q;
        end
      end
      ST_HOLD: begin
        if (we_q) begin
          pad_tn_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_TURN;
        end
      end
      ST_TURN: begin
        pad_tn_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        pad_tn_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      pad_addr_q <= '0;
      pad_a_q    <= '0;
      pad_tn_q   <= 1'b0;
      n_rd_q     <= 1'b1;
      n_wr_q     <= 1'b1;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      pad_addr_q <= pad_addr_d;
      pad_a_q    <= pad_a_d;
      pad_tn_q   <= pad_tn_d;
      n_rd_q     <= n_rd_d;
      n_wr_q     <= n_wr_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign Ack     = ack_q;
  assign RData   = rdata_q;
  assign PadAddr = pad_addr_q;
  assign PadA    = pad_a_q;
  assign PadTN   = pad_tn_q;
  assign nRD     = n_rd_q;
  assign nWR     = n_wr_q;

endmodule : bidir_bus_ctrl
`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bidir_bus_ctrl
//  Purpose  : Scoreboard bench for bidir_bus_ctrl with WAIT_STATES=2 and 0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bidir_bus_ctrl;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  zi;
    int          ack_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  zi;
  logic        test_en;
  logic        sel;
  logic        req0, req1;
  logic        ack0, ack1, tn0, tn1, nrd0, nrd1, nwr0, nwr1;
  logic [7:0]  rdata0, rdata1, pada0, pada1;
  logic [15:0] padaddr0, padaddr1;
  logic        m_ack, m_tn, m_nrd, m_nwr;
  logic [7:0]  m_rdata, m_pada;
  logic [15:0] m_padaddr;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req0      = req & ~sel;
  assign req1      = req & sel;
  assign m_ack     = sel ? ack1 : ack0;
  assign m_tn      = sel ? tn1 : tn0;
  assign m_nrd     = sel ? nrd1 : nrd0;
  assign m_nwr     = sel ? nwr1 : nwr0;
  assign m_rdata   = sel ? rdata1 : rdata0;
  assign m_pada    = sel ? pada1 : pada0;
  assign m_padaddr = sel ? padaddr1 : padaddr0;

  bidir_bus_ctrl #(.DW(8), .AW(16), .WAIT_STATES(2)) dut (
    .MasterClock(clk), .Reset(rst), .Req(req0), .We(we), .Addr(addr),
    .WData(wdata), .Ack(ack0), .RData(rdata0), .TestEn(test_en),
    .PadAddr(padaddr0), .PadA(pada0), .PadTN(tn0), .PadZI(zi),
    .nRD(nrd0), .nWR(nwr0)
  );

  bidir_bus_ctrl #(.DW(8), .AW(16), .WAIT_STATES(0)) dut_ws0 (
    .MasterClock(clk), .Reset(rst), .Req(req1), .We(we), .Addr(addr),
    .WData(wdata), .Ack(ack1), .RData(rdata1), .TestEn(test_en),
    .PadAddr(padaddr1), .PadA(pada1), .PadTN(tn1), .PadZI(zi),
    .nRD(nrd1), .nWR(nwr1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle accumulation against the head transaction, compare on Ack.
  initial begin
    exp_t       e;
    int         ws;
    int         n_wrl, n_rdl, n_tn;
    bit         bad_a, bad_addr, prev_rst;
    logic [7:0] last_rd;
    n_wrl = 0; n_rdl = 0; n_tn = 0; bad_a = 0; bad_addr = 0;
    prev_rst = 0; last_rd = 8'h00;
    forever begin
      @(negedge clk);
      ws = sel ? 0 : 2;
      if (rst) begin
        prev_rst = 1; last_rd = 8'h00;
        n_wrl = 0; n_rdl = 0; n_tn = 0; bad_a = 0; bad_addr = 0;
        continue;
      end
      if (prev_rst) begin
        prev_rst = 0;
        check("rst_ack", m_ack, 0);
        check("rst_strobes", {m_nrd, m_nwr}, 2'b11);
        check("rst_padtn", m_tn, 0);
        check("rst_pada", m_pada, 0);
        check("rst_padaddr", m_padaddr, 0);
        check("rst_rdata", m_rdata, 0);
      end
      if (sb.size() == 0) begin
        check("idle_quiet_ack_nrd_nwr_tn", {m_ack, m_nrd, m_nwr, m_tn}, 4'b0110);
      end else begin
        e = sb[0];
        if (!m_nwr) n_wrl++;
        if (!m_nrd) n_rdl++;
        if (m_tn) begin
          n_tn++;
          if (m_pada !== e.wdata) bad_a = 1;
        end
        if ((m_tn || !m_nrd || !m_nwr || m_ack) && (m_padaddr !== e.addr)) bad_addr = 1;
        if (m_ack) begin
          check("ack_latency_cycle", cyc, e.ack_cyc);
          check(e.we ? "nwr_low_cycles" : "nrd_low_cycles", e.we ? n_wrl : n_rdl, ws + 1);
          check("wrong_strobe_cycles", e.we ? n_rdl : n_wrl, 0);
          check("padtn_cycles", n_tn, e.we ? ws + 3 : 0);
          check("rdata_at_ack", m_rdata, e.we ? last_rd : e.zi);
          check("pad_a_addr_held", {bad_a, bad_addr}, 2'b00);
          if (!e.we) last_rd = e.zi;
          void'(sb.pop_front());
          n_wrl = 0; n_rdl = 0; n_tn = 0; bad_a = 0; bad_addr = 0;
        end else if (cyc > e.ack_cyc) begin
          check("ack_timeout", 0, 1);
          void'(sb.pop_front());
          n_wrl = 0; n_rdl = 0; n_tn = 0; bad_a = 0; bad_addr = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] z);
    we = w; addr = a; wdata = d; zi = z; req = 1'b1;
  endtask

  // Acceptance expected `off` cycles from now; Ack WAIT_STATES+3 cycles after that.
  task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] z, input int off);
    exp_t e;
    e.we = w; e.addr = a; e.wdata = d; e.zi = z;
    e.ack_cyc = cyc + off + (sel ? 0 : 2) + 3;
    sb.push_back(e);
  endtask

  task automatic start(input logic w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] z, input int off);
    drive(w, a, d, z);
    push(w, a, d, z, off);
  endtask

  task automatic wait_ack;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (m_ack) break;
    end
  endtask

  task automatic finish_access;
    wait_ack;
    req = 1'b0;
    zi  = 8'h99;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick;
    end
    tick;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    zi = 8'h99; test_en = 1'b0; sel = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;

    // WAIT_STATES=2: plain write and read
    start(1'b1, 16'h1234, 8'hA5, 8'h99, 0); finish_access;
    start(1'b0, 16'h0042, 8'h00, 8'h3C, 0); finish_access;

    // Read then write with Req held: TURN delays the write acceptance
    start(1'b0, 16'h0100, 8'h00, 8'hC3, 0); wait_ack;
    start(1'b1, 16'h0200, 8'h66, 8'h99, 2); finish_access;

    // Write then write with Req held
    start(1'b1, 16'h0300, 8'h11, 8'h99, 0); wait_ack;
    start(1'b1, 16'h0301, 8'h22, 8'h99, 1); finish_access;

    // TestEn blocks acceptance; rising mid-access does not abort
    test_en = 1'b1;
    drive(1'b1, 16'h0400, 8'h77, 8'h99);
    repeat (5) tick;
    test_en = 1'b0;
    push(1'b1, 16'h0400, 8'h77, 8'h99, 0);
    tick; tick;
    test_en = 1'b1;
    finish_access;
    test_en = 1'b0;
    tick;

    // Read to load RData, then reset in the 2nd STROBE cycle of a write
    start(1'b0, 16'h0500, 8'h00, 8'h81, 0); finish_access;
    start(1'b1, 16'h0700, 8'hF0, 8'h99, 0);
    repeat (3) tick;
    rst = 1'b1; req = 1'b0; sb.delete();
    tick;
    rst = 1'b0;
    repeat (3) tick;
    start(1'b1, 16'h0600, 8'h42, 8'h99, 0); finish_access;

    // WAIT_STATES=0 instance
    sel = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    start(1'b1, 16'hBEEF, 8'h3C, 8'h99, 0); finish_access;
    start(1'b0, 16'h0007, 8'h00, 8'hE7, 0); wait_ack;
    start(1'b1, 16'h0008, 8'h18, 8'h99, 2); finish_access;
    repeat (3) tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bidir_bus_ctrl
`default_nettype wire
